adc_sample_mem_writer: RTL
==========================

// Module: adc_sample_mem_writer
// PURPOSE
//   Capture engine placed between the ADC sample stream and the 40000x32 on-chip RAM slave port.
//   - Accepts channel-tagged 12-bit samples over a valid/ready stream.
//   - Writes them to consecutive RAM words, either a fixed-length capture or a continuous circular buffer.
//   - Reports progress and status for the HPS/Nios software that reads the buffer back.
// PARAMETERS
//   ADDR_W    16     RAM word-address width
//   DEPTH     40000  RAM depth in 32-bit words; wrap point is DEPTH-1 -> 0
//   SAMPLE_W  12     ADC sample width
// PORTS
//   clk             in   1        system clock
//   reset_n         in   1        asynchronous active-low reset
//   ctrl_start      in   1        pulse: begin capture (clears counters and status)
//   ctrl_stop       in   1        pulse: end capture early
//   ctrl_length     in   ADDR_W   words to capture; 0 = continuous circular
//   smp_valid       in   1        sample present
//   smp_data        in   SAMPLE_W sample value
//   smp_channel     in   3        ADC channel of sample
//   smp_ready       out  1        sample accepted when smp_valid & smp_ready
//   mem_address     out  ADDR_W   RAM word address
//   mem_byteenable  out  4        RAM byte enables
//   mem_chipselect  out  1        RAM select, asserted together with mem_write
//   mem_write       out  1        RAM write strobe (single cycle, no wait states)
//   mem_writedata   out  32       RAM write data
//   status_busy     out  1        state == CAPTURE
//   status_done     out  1        state == DONE
//   status_wrap     out  1        sticky: address wrapped at least once
//   status_overrun  out  1        sticky: smp_valid seen while in DONE
//   status_words    out  ADDR_W   words written since start (saturates at DEPTH)
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, address/counters 0. Async assert; deassert is synchronous to clk.
//   Reset mid-capture aborts immediately; no further writes are issued.
//   States: IDLE -(start & ~stop)-> CAPTURE -(length reached | stop)-> DONE -(start)-> CAPTURE.
//     - start and stop in the same cycle in IDLE/DONE: stop wins, state unchanged.
//     - start while in CAPTURE: ignored.
//   On start:
//     - len_eff = min(ctrl_length, DEPTH) latched; ctrl_length==0 latches continuous mode.
//     - address, seq, status_words, status_wrap, status_overrun all cleared.
//   smp_ready = 1 exactly while in CAPTURE (the RAM never stalls).
//   Write latency: the cycle after an accepted sample, mem_write = mem_chipselect = 1 for exactly one cycle.
//     - Data, address and byteenable are registered on the same edge as the write strobe.
//     - Back-to-back samples give back-to-back writes.
//   Word format: [31:16] seq (accepted-sample count since start, mod 2^16), [15]=0,
//     [14:12] channel, [11:0] data. mem_byteenable = 4'hF.
//   Address advances by 1 after every word write; DEPTH-1 -> 0 sets status_wrap.
//   status_words increments on every write whose byteenable[0] = 1, saturating at DEPTH.
//   Fixed-length mode: the write of word len_eff-1 moves CAPTURE -> DONE.
//     - smp_ready drops in the cycle after the last accept, so no extra sample is taken.
//   Continuous mode: runs until ctrl_stop.
//   ctrl_stop in CAPTURE:
//     - A sample accepted in the same cycle is still written.
//     - Then DONE; smp_ready = 0 from the next cycle.
//   In DONE, smp_valid = 1 sets status_overrun; the sample is dropped.
// CONFIGURATION
//   ADC_WRITER_HALFWORD_EN defined: two samples per word, each half = {1'b0, channel, data}.
//     - First sample of a pair -> [15:0], byteenable 4'b0011.
//     - Second sample -> [31:16], byteenable 4'b1100.
//     - Address advances only after the upper-half write.
//     - Length counts words; DONE follows the upper-half write of word len_eff-1.
//     - Stop after a lower half leaves the upper half unwritten, and the address does not advance.
//     - seq is not stored in this mode.
//   Macro undefined: one sample per word, format as above, byteenable always 4'hF.
// TESTING
//   1. length=4, 4 samples ch2 data 0x123.. on consecutive cycles:
//      -> 4 back-to-back writes at addr 0..3, data 0x0000_2123 / 0x0001_2124...,
//         status_words = 4, done = 1, smp_ready = 0.
//   2. length=0, 40002 samples:
//      -> writes reach 39999, then 0 and 1; wrap = 1; status_words = 40000; busy until stop.
//   3. length=8, stop pulsed together with the 3rd accept:
//      -> 3 writes (addr 0..2), then DONE; the following smp_valid sets overrun.
//   4. reset_n low one cycle after the 2nd accept:
//      -> no mem_write from that point; all outputs 0; a restart writes from addr 0 again.
//   5. start+stop together in IDLE -> remains IDLE; start while busy -> counters unchanged.
//   6. HALFWORD_EN, length=2, 4 samples:
//      -> byteenables 0011, 1100, 0011, 1100 at addr 0, 0, 1, 1; status_words = 2; done.

Source files
------------

// File: rtl/adc_sample_mem_writer_if.sv
// Sample stream, RAM write port, control and status bundle for the ADC capture writer.
// The writer side uses modport slave; the driving side (software/stream source) uses modport master.
interface adc_sample_mem_writer_if #(
  parameter int ADDR_W   = 16,
  parameter int SAMPLE_W = 12
);
  logic                ctrl_start;
  logic                ctrl_stop;
  logic [ADDR_W-1:0]   ctrl_length;
  logic                smp_valid;
  logic [SAMPLE_W-1:0] smp_data;
  logic [2:0]          smp_channel;
  logic                smp_ready;
  logic [ADDR_W-1:0]   mem_address;
  logic [3:0]          mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [31:0]         mem_writedata;
  logic                status_busy;
  logic                status_done;
  logic                status_wrap;
  logic                status_overrun;
  logic [ADDR_W-1:0]   status_words;

  modport slave (
    input  ctrl_start, ctrl_stop, ctrl_length, smp_valid, smp_data, smp_channel,
    output smp_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    output status_busy, status_done, status_wrap, status_overrun, status_words
  );

  modport master (
    output ctrl_start, ctrl_stop, ctrl_length, smp_valid, smp_data, smp_channel,
    input  smp_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    input  status_busy, status_done, status_wrap, status_overrun, status_words
  );
endinterface

// File: rtl/adc_sample_mem_writer.sv
// Captures channel-tagged ADC samples into consecutive RAM words (fixed-length or circular).
// Optional: define ADC_WRITER_HALFWORD_EN to pack two samples per word.
module adc_sample_mem_writer #(
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 40000,
  parameter int SAMPLE_W = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  adc_sample_mem_writer_if.slave  bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_W   = ADDR_W'(DEPTH);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] len_reg;
  logic [ADDR_W-1:0] words_reg;
  logic [ADDR_W-1:0] mem_address_reg;
  logic              continuous_reg;
  logic              wrap_reg;
  logic              overrun_reg;
  logic [15:0]       seq_reg;
  logic              mem_write_reg;
  logic [3:0]        byteenable_reg;
  logic [31:0]       writedata_reg;
`ifdef ADC_WRITER_HALFWORD_EN
  logic              upper_reg;
`endif

  logic              capture;
  logic              accept;
  logic              start_go;
  logic              word_end;
  logic              last_word;
  logic [15:0]       half_word;
  logic [ADDR_W-1:0] len_eff;

  assign capture   = (state_reg == ST_CAPTURE);
  assign accept    = bus.smp_valid & capture;
  // stop has priority over start, and start is ignored while capturing
  assign start_go  = bus.ctrl_start & ~bus.ctrl_stop & ~capture;
  assign half_word = 16'({1'b0, bus.smp_channel, bus.smp_data});
  assign len_eff   = (bus.ctrl_length > DEPTH_W) ? DEPTH_W : bus.ctrl_length;
  assign last_word = ~continuous_reg & (addr_reg == len_reg - 1'b1);
`ifdef ADC_WRITER_HALFWORD_EN
  assign word_end  = upper_reg;
`else
  assign word_end  = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      len_reg         <= '0;
      words_reg       <= '0;
      mem_address_reg <= '0;
      continuous_reg  <= 1'b0;
      wrap_reg        <= 1'b0;
      overrun_reg     <= 1'b0;
      seq_reg         <= '0;
      mem_write_reg   <= 1'b0;
      byteenable_reg  <= '0;
      writedata_reg   <= '0;
`ifdef ADC_WRITER_HALFWORD_EN
      upper_reg       <= 1'b0;
`endif
    end else begin
      mem_write_reg <= accept;
      if (mem_write_reg && byteenable_reg[0] && (words_reg != DEPTH_W))
        words_reg <= words_reg + 1'b1;

      if (capture) begin
        if (accept) begin
          seq_reg         <= seq_reg + 1'b1;
          mem_address_reg <= addr_reg;
`ifdef ADC_WRITER_HALFWORD_EN
          upper_reg       <= ~upper_reg;
          if (upper_reg) begin
            byteenable_reg <= 4'b1100;
            writedata_reg  <= {half_word, 16'h0000};
          end else begin
            byteenable_reg <= 4'b0011;
            writedata_reg  <= {16'h0000, half_word};
          end
`else
          byteenable_reg  <= 4'hF;
          writedata_reg   <= {seq_reg, half_word};
`endif
          if (word_end) begin
            if (addr_reg == LAST_ADDR) begin
              addr_reg <= '0;
              wrap_reg <= 1'b1;
            end else begin
              addr_reg <= addr_reg + 1'b1;
            end
          end
        end
        if (bus.ctrl_stop || (accept && word_end && last_word))
          state_reg <= ST_DONE;
      end else if (start_go) begin
        // a fresh capture discards all progress, including a write retiring this cycle
        state_reg      <= ST_CAPTURE;
        len_reg        <= len_eff;
        continuous_reg <= (bus.ctrl_length == '0);
        addr_reg       <= '0;
        seq_reg        <= '0;
        words_reg      <= '0;
        wrap_reg       <= 1'b0;
        overrun_reg    <= 1'b0;
`ifdef ADC_WRITER_HALFWORD_EN
        upper_reg      <= 1'b0;
`endif
      end else if ((state_reg == ST_DONE) && bus.smp_valid) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign bus.smp_ready      = capture;
  assign bus.mem_address    = mem_address_reg;
  assign bus.mem_byteenable = byteenable_reg;
  assign bus.mem_chipselect = mem_write_reg;
  assign bus.mem_write      = mem_write_reg;
  assign bus.mem_writedata  = writedata_reg;
  assign bus.status_busy    = capture;
  assign bus.status_done    = (state_reg == ST_DONE);
  assign bus.status_wrap    = wrap_reg;
  assign bus.status_overrun = overrun_reg;
  assign bus.status_words   = words_reg;
endmodule
